// File: rtl/rename_pkg.sv
// Shared rename constants and types: physical tag width, free-list pointer width.
package rename_pkg;

   localparam int unsigned NUM_PHYS = 64;
   localparam int unsigned NUM_ARCH = 32;
   localparam int unsigned DEPTH    = NUM_PHYS - NUM_ARCH;
   localparam int unsigned TAG_W    = $clog2(NUM_PHYS);
   localparam int unsigned IDX_W    = $clog2(DEPTH);
   // One extra bit distinguishes full from empty when indices match.
   localparam int unsigned PTR_W    = IDX_W + 1;

   typedef logic [TAG_W-1:0] phys_tag_t;
   typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/phys_free_list.sv
// Circular free list of physical tags with a committed head for one-cycle flush recovery.
module phys_free_list
   import rename_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc_req,
   output logic             alloc_valid,
   output logic [TAG_W-1:0] alloc_phys,
   input  logic             free_en,
   input  logic [TAG_W-1:0] free_phys,
   input  logic             commit_adv,
   input  logic             flush,
   output logic [PTR_W-1:0] free_count,
   output logic             overflow_err,
   output logic             underflow_err
);

   ptr_t      head_q, head_d;
   ptr_t      rhead_q, rhead_d;
   ptr_t      tail_q, tail_d;
   phys_tag_t mem_q [DEPTH];
   logic      overflow_q, overflow_d;
   logic      underflow_q, underflow_d;

   ptr_t      occupied;
   logic      full;
   logic      free_nz;
   logic      pop;
   logic      push;
   logic      commit_ok;

   // Head-facing outputs depend only on registered state (no free-to-alloc bypass).
   always_comb begin
      alloc_valid   = (head_q != tail_q);
      alloc_phys    = mem_q[head_q[IDX_W-1:0]];
      free_count    = tail_q - head_q;
      overflow_err  = overflow_q;
      underflow_err = underflow_q;
   end

   // Pointer and error-flag next state; full is measured against the committed head.
   always_comb begin
      occupied    = tail_q - rhead_q;
      full        = (occupied == ptr_t'(DEPTH));
      free_nz     = free_en & (free_phys != '0);
      pop         = alloc_req & alloc_valid & ~flush;
      push        = free_nz & ~full;
      commit_ok   = commit_adv & (rhead_q != head_q);
      rhead_d     = rhead_q + ptr_t'(commit_ok);
      head_d      = flush ? rhead_d : head_q + ptr_t'(pop);
      tail_d      = tail_q + ptr_t'(push);
      overflow_d  = overflow_q | (free_nz & full);
      underflow_d = underflow_q | (alloc_req & ~alloc_valid) | (commit_adv & ~commit_ok);
   end

   // Pointer and sticky-flag registers; reset leaves the ring full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q      <= '0;
         rhead_q     <= '0;
         tail_q      <= ptr_t'(DEPTH);
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         rhead_q     <= rhead_d;
         tail_q      <= tail_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Tag storage; reset loads the tags not taken by the identity architectural map.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= phys_tag_t'(NUM_ARCH + i);
         end
      end else if (push) begin
         mem_q[tail_q[IDX_W-1:0]] <= free_phys;
      end
   end

endmodule
